// File: rtl/sqta_microprogram_engine_if.sv
// Bundle of run control, qualifier, microstore-write and observation signals
// for the SQTA microprogram engine.
interface sqta_microprogram_engine_if #(
  parameter int NUM_IN     = 3,
  parameter int NUM_OUT    = 3,
  parameter int STATE_BITS = 3,
  parameter int CNT_W      = 8
);
  localparam int TW = $clog2(NUM_IN + 1);
  localparam int W  = TW + 2*STATE_BITS + NUM_OUT;

  logic                  Run;
  logic                  Step;
  logic [NUM_IN-1:0]     X;
  logic                  Wr_en;
  logic [STATE_BITS-1:0] Wr_addr;
  logic [W-1:0]          Wr_data;
  logic [NUM_OUT-1:0]    Z;
  logic [STATE_BITS-1:0] State;
  logic                  Halted;
  logic [CNT_W-1:0]      Cycles;
  logic                  Wr_err;

  modport master (
    output Run, Step, X, Wr_en, Wr_addr, Wr_data,
    input  Z, State, Halted, Cycles, Wr_err
  );

  modport slave (
    input  Run, Step, X, Wr_en, Wr_addr, Wr_data,
    output Z, State, Halted, Cycles, Wr_err
  );
endinterface

// File: rtl/sqta_microprogram_engine.sv
// Single-qualifier two-address microprogrammed sequencer with a runtime-writable
// microstore, run/step control, halt detection and a saturating advance counter.
module sqta_microprogram_engine #(
  parameter int NUM_IN     = 3,
  parameter int NUM_OUT    = 3,
  parameter int STATE_BITS = 3,
  parameter int CNT_W      = 8
) (
  input logic                     Clk,
  input logic                     Rst_n,
  sqta_microprogram_engine_if.slave bus
);
  localparam int TW    = $clog2(NUM_IN + 1);
  localparam int W     = TW + 2*STATE_BITS + NUM_OUT;
  localparam int DEPTH = 2**STATE_BITS;
  localparam logic [TW-1:0] NUM_IN_T = TW'(NUM_IN);

  logic [W-1:0]          mem [DEPTH];
  logic [STATE_BITS-1:0] state_q;
  logic [CNT_W-1:0]      cycles_q;
  logic                  wr_err_q;

  logic [W-1:0]          cur_word;
  logic [TW-1:0]         test_f;
  logic [STATE_BITS-1:0] next0_f;
  logic [STATE_BITS-1:0] next1_f;
  logic [STATE_BITS-1:0] next_state;
  logic [2**TW-1:0]      x_ext;
  logic                  uncond;
  logic                  halted;
  logic                  go;
  logic                  adv;
  logic                  wr_ok;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // TEST codes beyond the last qualifier select the unconditional branch;
  // padding X to a power of two keeps the qualifier select fully indexed.
  always_comb begin
    cur_word             = mem[state_q];
    test_f               = cur_word[TW-1:0];
    next0_f              = cur_word[TW +: STATE_BITS];
    next1_f              = cur_word[TW+STATE_BITS +: STATE_BITS];
    x_ext                = '0;
    x_ext[NUM_IN-1:0]    = bus.X;
    uncond               = (test_f >= NUM_IN_T);
    next_state           = (!uncond && x_ext[test_f]) ? next1_f : next0_f;
    halted               = uncond && (next0_f == state_q);
    go                   = bus.Run | bus.Step;
    adv                  = go & ~halted;
    wr_ok                = bus.Wr_en & ~go;
  end

  // Reset clears the microstore too, so a program must be reloaded after it.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q  <= '0;
      cycles_q <= '0;
      wr_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (adv) begin
        state_q  <= next_state;
        cycles_q <= sat_inc(cycles_q);
      end
      if (wr_ok) mem[bus.Wr_addr] <= bus.Wr_data;
      wr_err_q <= bus.Wr_en & go;
    end
  end

  assign bus.Z      = cur_word[W-1 -: NUM_OUT];
  assign bus.State  = state_q;
  assign bus.Halted = halted;
  assign bus.Cycles = cycles_q;
  assign bus.Wr_err = wr_err_q;
endmodule
